fmul_arbiter: RTL and testbench

FMUL_ARBITER -- requirements
Module: fmul_arbiter

---
 rtl/fmul_arbiter.sv | 116 +++++++++++
 tb/tb_fmul_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
// Two-requester arbiter in front of one shared combinational FP multiplier.
// Define FMUL_ARB_FLAG_ACC_EN to enable the sticky fflags accumulator.
module fmul_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [1:0]  req_rm,
  input  logic [1:0]  req_mode,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_rm,
  output logic        mul_mode,
  input  logic [31:0] mul_result,
  input  logic [4:0]  mul_flags,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic        busy,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   id;
  logic   win;
  logic   grant_any;

  // Winner selection; acceptance is a same-cycle handshake while IDLE.
  always_comb begin
    grant_any = |req_valid;
    win       = 1'b0;
    case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = FIXED_PRIO ? 1'b0 : ~last_grant;
      default: win = 1'b0;
    endcase
    req_ready = '0;
    if (rst_n && state == IDLE && grant_any) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id          <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_rm      <= 1'b0;
      mul_mode    <= 1'b0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= EXEC;
            busy       <= 1'b1;
            id         <= win;
            last_grant <= win;
            mul_a      <= win ? req_a[63:32] : req_a[31:0];
            mul_b      <= win ? req_b[63:32] : req_b[31:0];
            mul_rm     <= req_rm[win];
            mul_mode   <= req_mode[win];
          end
        end
        EXEC: begin
          resp_result <= mul_result;
          resp_flags  <= mul_flags;
          resp_valid  <= id ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          // Only the granted requester's resp_ready completes the response.
          if (resp_ready[id]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FMUL_ARB_FLAG_ACC_EN
  // A capture in the same cycle as a clear keeps the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= '0;
    end else if (state == EXEC) begin
      fflags <= (fflags_clr ? 5'b0 : fflags) | mul_flags;
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr;
  assign fflags            = '0;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter: round-robin DUT plus a fixed-priority twin,
// each fed by a small table-driven multiplier model.
module tb_fmul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_rm, req_mode, resp_ready;
  logic [63:0] req_a, req_b;
  logic        fflags_clr;

  logic [1:0]  req_ready, resp_valid;
  logic [31:0] mul_a, mul_b, mul_result, resp_result;
  logic        mul_rm, mul_mode, busy;
  logic [4:0]  mul_flags, resp_flags, fflags;

  logic [1:0]  fp_req_ready, fp_resp_valid;
  logic [31:0] fp_mul_a, fp_mul_b, fp_mul_result, fp_resp_result;
  logic        fp_mul_rm, fp_mul_mode, fp_busy;
  logic [4:0]  fp_mul_flags, fp_resp_flags, fp_fflags;

  int n_checks = 0;
  int n_fail   = 0;

  // Known products for the directed vectors; anything else flags inexact.
  function automatic logic [36:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic m);
    if (m && a == 32'h3FC00000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
    if (m && a == 32'h7F800000 && b == 32'h00000000) return {5'b10000, 32'h7FC00000};
    if (!m && a[15:0] == 16'h3C00 && b[15:0] == 16'h4000) return {5'b00000, 32'h00004000};
    return {5'b00001, a + b};
  endfunction

  assign {mul_flags, mul_result}       = mul_model(mul_a, mul_b, mul_mode);
  assign {fp_mul_flags, fp_mul_result} = mul_model(fp_mul_a, fp_mul_b, fp_mul_mode);

  fmul_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_mode(req_mode),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm), .mul_mode(mul_mode),
    .mul_result(mul_result), .mul_flags(mul_flags), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  fmul_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_mode(req_mode),
    .mul_a(fp_mul_a), .mul_b(fp_mul_b), .mul_rm(fp_mul_rm), .mul_mode(fp_mul_mode),
    .mul_result(fp_mul_result), .mul_flags(fp_mul_flags), .resp_valid(fp_resp_valid),
    .resp_ready(resp_ready), .resp_result(fp_resp_result), .resp_flags(fp_resp_flags),
    .busy(fp_busy), .fflags(fp_fflags), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

`ifdef FMUL_ARB_FLAG_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction from requester r, optionally stalling RESP for hold cycles.
  task automatic run_op(input string tag, input int r, input logic [31:0] a,
                        input logic [31:0] b, input logic m, input int hold,
                        input logic clr_exec);
    logic [36:0] e;
    logic [1:0]  oh;
    e  = mul_model(a, b, m);
    oh = (r == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    req_valid = oh;
    req_a     = (r == 1) ? {a, 32'hDEADBEEF} : {32'hDEADBEEF, a};
    req_b     = (r == 1) ? {b, 32'h12345678} : {32'h12345678, b};
    req_mode  = (r == 1) ? {m, ~m} : {~m, m};
    #1 check({tag, "_ready"}, 64'(req_ready), 64'(oh));
    @(negedge clk);
    req_valid  = '0;
    fflags_clr = clr_exec;
    #1;
    check({tag, "_exec_busy"}, 64'(busy), 64'(1'b1));
    check({tag, "_exec_rv"}, 64'(resp_valid), 64'(2'b00));
    check({tag, "_mul_a"}, 64'(mul_a), 64'(a));
    @(negedge clk);
    fflags_clr = 1'b0;
    #1;
    check({tag, "_rv"}, 64'(resp_valid), 64'(oh));
    check({tag, "_result"}, 64'(resp_result), 64'(e[31:0]));
    check({tag, "_flags"}, 64'(resp_flags), 64'(e[36:32]));
    for (int i = 0; i < hold; i++) begin
      req_valid  = 2'b11;
      resp_ready = ~oh;
      #1;
      check({tag, "_hold_ready"}, 64'(req_ready), 64'(2'b00));
      check({tag, "_hold_busy"}, 64'(busy), 64'(1'b1));
      check({tag, "_hold_result"}, 64'(resp_result), 64'(e[31:0]));
      check({tag, "_hold_rv"}, 64'(resp_valid), 64'(oh));
      @(negedge clk);
    end
    resp_ready = oh;
    req_valid  = '0;
    @(negedge clk);
    #1;
    check({tag, "_done_rv"}, 64'(resp_valid), 64'(2'b00));
    check({tag, "_done_busy"}, 64'(busy), 64'(1'b0));
    resp_ready = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_mul_ab"}, {mul_a, mul_b}, 64'(0));
    check({tag, "_mul_ctl"}, 64'({mul_rm, mul_mode}), 64'(0));
    check({tag, "_resp_data"}, 64'({resp_flags, resp_result}), 64'(0));
    check({tag, "_fflags"}, 64'(fflags), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_rm = '0; req_mode = '0; resp_ready = '0;
    req_a = '0; req_b = '0; fflags_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // No request, no operation.
    @(negedge clk);
    #1 check("idle_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1 check("idle_busy", 64'(busy), 64'(0));

    run_op("fp32", 0, 32'h3FC00000, 32'h40000000, 1'b1, 0, 1'b0);
    run_op("stall", 1, 32'h3FC00000, 32'h40000000, 1'b1, 5, 1'b0);
    run_op("fp16", 0, 32'h00003C00, 32'h00004000, 1'b0, 0, 1'b0);
    run_op("inv", 1, 32'h7F800000, 32'h00000000, 1'b1, 0, 1'b0);
    check("ff_inv", 64'(fflags), ACC ? 64'(5'b10000) : 64'(0));
    run_op("inx", 0, 32'h11111111, 32'h22222222, 1'b1, 0, 1'b0);
    check("ff_acc", 64'(fflags), ACC ? 64'(5'b10001) : 64'(0));
    @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    #1 check("ff_clr", 64'(fflags), 64'(0));
    run_op("clrwin", 1, 32'h7F800000, 32'h00000000, 1'b1, 0, 1'b1);
    check("ff_clrwin", 64'(fflags), ACC ? 64'(5'b10000) : 64'(0));

    // Abort a requester-0 op in EXEC; round-robin alone would then favour requester 1.
    @(negedge clk);
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h3FC00000};
    req_b     = {32'h0, 32'h40000000};
    req_mode  = 2'b11;
    #1 check("abort_ready", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = '0;
    #1 check("abort_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("abort_no_resp", 64'({busy, resp_valid}), 64'(0));
    end

    // Both requesters held: round-robin alternates, fixed priority always picks 0.
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      if (k < 3) check("fp_grant", 64'(fp_req_ready), 64'(2'b01));
      @(negedge clk);
      @(negedge clk);
      #1 check("rr_resp", 64'(resp_valid), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      @(negedge clk);
    end
    req_valid  = '0;
    resp_ready = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
